// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the multicycle sequencer
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR} seq_state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_ILLEGAL = 2'b01, ERR_TIMEOUT = 2'b10} seq_err_t;
  localparam int SEQ_TIMEOUT = 16;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts unacknowledged bus wait cycles and flags expiry
module bus_watchdog #(
  parameter int TIMEOUT = cpu_pkg::SEQ_TIMEOUT
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  // expiry is combinational so the FSM can leave on the same cycle the limit is hit
  assign expire = (TIMEOUT != 0) && en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/exec/mem/wb controller sharing one req/ack memory bus
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = SEQ_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             illegal,
  input  logic             bus_ack,
  output logic             bus_req,
  output logic             bus_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_load,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instret
);
  seq_state_t cur, nxt;
  seq_err_t   err_q;
  logic       mr_q, mw_q, rw_q;
  logic       bus_phase, expire;
  assign bus_phase = (cur == FETCH) || (cur == MEM);
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (!bus_phase || bus_ack),
    .en     (bus_phase && !bus_ack),
    .expire (expire)
  );
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) cur <= IDLE;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = run ? FETCH : IDLE;
      FETCH:   nxt = bus_ack ? DECODE : expire ? ERROR : FETCH;
      DECODE:  nxt = illegal ? ERROR : EXEC;
      EXEC:    nxt = (mr_q || mw_q) ? MEM : WB;
      MEM:     nxt = bus_ack ? WB : expire ? ERROR : MEM;
      WB:      nxt = halt_req ? HALT : FETCH;
      HALT:    nxt = (run && !halt_req) ? FETCH : HALT;
      default: nxt = ERROR;
    endcase
  end
  always_comb begin
    bus_req  = bus_phase;
    bus_we   = (cur == MEM) && mw_q;
    addr_sel = cur == MEM;
    ir_load  = (cur == FETCH) && bus_ack;
    pc_load  = cur == WB;
    reg_we   = (cur == WB) && rw_q;
    error    = cur == ERROR;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= ERR_NONE;
      instret <= '0;
    end else begin
      if (cur == DECODE && !illegal) begin
        mr_q <= mem_read;
        mw_q <= mem_write;
        rw_q <= reg_write;
      end
      if (cur == DECODE && illegal) err_q <= ERR_ILLEGAL;
      if (bus_phase && expire) err_q <= ERR_TIMEOUT;
      if (cur == WB) instret <= instret + 1'b1;
    end
  assign state    = cur;
  assign err_code = err_q;
endmodule
